jtag_axi_mem_slave: RTL and testbench

AXI4 responder terminating the AXI master port of the JTAG-to-AXI bridge: a word-addressed on-chip memory that accepts single and burst reads and writes issued over JTAG. It sits on the `clk_axi` domain and plugs directly onto `jtag_axi_mosi_o` / `jtag_axi_miso_i`. It gives FPGA and simulation builds a real target in place of the tied-off response bus. One transaction is in flight at a time.

---
 rtl/jtag_axi_mem_slave.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_jtag_axi_mem_slave.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_axi_mem_slave.sv
// jtag_axi_mem_slave: word-addressed AXI4 memory that answers the JTAG-to-AXI bridge.
// It takes single and burst reads and writes, with one transaction in flight at a time.
// Optional build macro JTAG_AXI_MEM_DECERR_EN: out-of-range beats return DECERR.
// Without the macro, out-of-range beats alias into memory modulo MEM_DEPTH.

package jtag_axi_mem_pkg;
   localparam int unsigned AXI_ID_W   = 4;
   localparam int unsigned AXI_ADDR_W = 32;
   localparam int unsigned AXI_DATA_W = 32;
   localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
   localparam int unsigned AXI_LEN_W  = 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   typedef struct packed {
      logic [AXI_ID_W-1:0]   awid;
      logic [AXI_ADDR_W-1:0] awaddr;
      logic [AXI_LEN_W-1:0]  awlen;
      logic [2:0]            awsize;
      logic [1:0]            awburst;
      logic                  awvalid;
      logic [AXI_DATA_W-1:0] wdata;
      logic [AXI_STRB_W-1:0] wstrb;
      logic                  wlast;
      logic                  wvalid;
      logic                  bready;
      logic [AXI_ID_W-1:0]   arid;
      logic [AXI_ADDR_W-1:0] araddr;
      logic [AXI_LEN_W-1:0]  arlen;
      logic [2:0]            arsize;
      logic [1:0]            arburst;
      logic                  arvalid;
      logic                  rready;
   } s_axi_mosi_t;

   typedef struct packed {
      logic                  awready;
      logic                  wready;
      logic [AXI_ID_W-1:0]   bid;
      logic [1:0]            bresp;
      logic                  bvalid;
      logic                  arready;
      logic [AXI_ID_W-1:0]   rid;
      logic [AXI_DATA_W-1:0] rdata;
      logic [1:0]            rresp;
      logic                  rlast;
      logic                  rvalid;
   } s_axi_miso_t;
endpackage

module jtag_axi_mem_slave
   import jtag_axi_mem_pkg::*;
#(
   parameter int unsigned          MEM_DEPTH = 256,
   parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk_axi,
   input  logic        ares_axi,
   input  s_axi_mosi_t axi_mosi_i,
   output s_axi_miso_t axi_miso_o
);

   localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
`ifdef JTAG_AXI_MEM_DECERR_EN
   localparam bit DECERR_EN = 1'b1;
`else
   localparam bit DECERR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

   // Word index of a byte address; the upper bits drop out, which gives the aliasing behaviour.
   function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_W-1:0] a);
      return IDX_W'((a - BASE_ADDR) >> 2);
   endfunction

   // True when the address falls outside the memory window and decode errors are enabled.
   function automatic logic decode_err(input logic [AXI_ADDR_W-1:0] a);
      logic [AXI_ADDR_W-1:0] words;
      words = (a - BASE_ADDR) >> 2;
      return DECERR_EN && ((a < BASE_ADDR) || (words >= AXI_ADDR_W'(MEM_DEPTH)));
   endfunction

   // Unsupported request: the transfer size is not 4 bytes, or the burst type is WRAP or reserved.
   function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst);
      return (size != 3'd2) || ((burst != BURST_FIXED) && (burst != BURST_INCR));
   endfunction

   // Combine two responses with priority SLVERR over DECERR over OKAY.
   function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
      if ((a == RESP_SLVERR) || (b == RESP_SLVERR)) return RESP_SLVERR;
      if ((a == RESP_DECERR) || (b == RESP_DECERR)) return RESP_DECERR;
      return RESP_OKAY;
   endfunction

   logic [AXI_DATA_W-1:0] mem [MEM_DEPTH];

   state_t                state_q;
   logic                  active_q;
   logic [AXI_ID_W-1:0]   id_q;
   logic [AXI_ADDR_W-1:0] addr_q;
   logic [AXI_LEN_W-1:0]  len_q;
   logic [AXI_LEN_W-1:0]  beat_q;
   logic                  fixed_q;
   logic                  err_q;
   logic [1:0]            wresp_q;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;
   logic                  rvalid_q;
   logic [AXI_DATA_W-1:0] rdata_q;
   logic [1:0]            rresp_q;
   logic                  rlast_q;

   logic                  idle_c;
   logic                  awready_c;
   logic                  arready_c;
   logic                  wready_c;
   logic                  aw_hs_c;
   logic                  ar_hs_c;
   logic                  w_hs_c;
   logic                  last_beat_c;
   logic [AXI_ADDR_W-1:0] next_addr_c;
   logic                  wr_dec_c;
   logic [1:0]            wr_resp_c;
   logic                  mem_we_c;
   logic [IDX_W-1:0]      wr_idx_c;
   logic [AXI_ADDR_W-1:0] rd_addr_c;
   logic                  rd_err_c;
   logic                  rd_dec_c;
   logic [AXI_DATA_W-1:0] rd_word_c;
   logic [AXI_DATA_W-1:0] rd_data_c;
   logic [1:0]            rd_resp_c;

   // Handshake decode, write-beat response, and lookup of the next read beat.
   always_comb begin
      idle_c      = active_q && (state_q == IDLE);
      awready_c   = idle_c;
      arready_c   = idle_c && !axi_mosi_i.awvalid;
      wready_c    = (state_q == WR_DATA);
      aw_hs_c     = axi_mosi_i.awvalid && awready_c;
      ar_hs_c     = axi_mosi_i.arvalid && arready_c;
      w_hs_c      = axi_mosi_i.wvalid && wready_c;
      last_beat_c = (beat_q == len_q);
      next_addr_c = fixed_q ? addr_q : (addr_q + 32'd4);

      wr_dec_c  = decode_err(addr_q);
      wr_idx_c  = word_idx(addr_q);
      wr_resp_c = RESP_OKAY;
      if (err_q || (axi_mosi_i.wlast != last_beat_c)) wr_resp_c = RESP_SLVERR;
      else if (wr_dec_c)                              wr_resp_c = RESP_DECERR;
      mem_we_c  = w_hs_c && !err_q && !wr_dec_c;

      rd_addr_c = (state_q == IDLE) ? axi_mosi_i.araddr : next_addr_c;
      rd_err_c  = (state_q == IDLE) ? req_err(axi_mosi_i.arsize, axi_mosi_i.arburst) : err_q;
      rd_dec_c  = decode_err(rd_addr_c);
      rd_word_c = mem[word_idx(rd_addr_c)];
      rd_data_c = rd_word_c;
      rd_resp_c = RESP_OKAY;
      if (rd_err_c) begin
         rd_data_c = '0;
         rd_resp_c = RESP_SLVERR;
      end else if (rd_dec_c) begin
         rd_data_c = '0;
         rd_resp_c = RESP_DECERR;
      end
   end

   // Byte-strobed memory write. Memory contents are not reset.
   always_ff @(posedge clk_axi) begin
      if (mem_we_c) begin
         for (int b = 0; b < int'(AXI_STRB_W); b++) begin
            if (axi_mosi_i.wstrb[b]) mem[wr_idx_c][8*b +: 8] <= axi_mosi_i.wdata[8*b +: 8];
         end
      end
   end

   // Transaction FSM with registered B and R channel outputs.
   always_ff @(posedge clk_axi or posedge ares_axi) begin
      if (ares_axi) begin
         state_q  <= IDLE;
         active_q <= 1'b0;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         beat_q   <= '0;
         fixed_q  <= 1'b0;
         err_q    <= 1'b0;
         wresp_q  <= RESP_OKAY;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
         rlast_q  <= 1'b0;
      end else begin
         active_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (aw_hs_c) begin
                  id_q    <= axi_mosi_i.awid;
                  addr_q  <= axi_mosi_i.awaddr;
                  len_q   <= axi_mosi_i.awlen;
                  fixed_q <= (axi_mosi_i.awburst == BURST_FIXED);
                  err_q   <= req_err(axi_mosi_i.awsize, axi_mosi_i.awburst);
                  beat_q  <= '0;
                  wresp_q <= RESP_OKAY;
                  state_q <= WR_DATA;
               end else if (ar_hs_c) begin
                  id_q     <= axi_mosi_i.arid;
                  addr_q   <= axi_mosi_i.araddr;
                  len_q    <= axi_mosi_i.arlen;
                  fixed_q  <= (axi_mosi_i.arburst == BURST_FIXED);
                  err_q    <= rd_err_c;
                  beat_q   <= '0;
                  rvalid_q <= 1'b1;
                  rdata_q  <= rd_data_c;
                  rresp_q  <= rd_resp_c;
                  rlast_q  <= (axi_mosi_i.arlen == 8'd0);
                  state_q  <= RD_DATA;
               end
            end
            WR_DATA: begin
               if (w_hs_c) begin
                  addr_q <= next_addr_c;
                  beat_q <= beat_q + 8'd1;
                  if (last_beat_c) begin
                     bvalid_q <= 1'b1;
                     bresp_q  <= worst(wresp_q, wr_resp_c);
                     state_q  <= WR_RESP;
                  end else begin
                     wresp_q <= worst(wresp_q, wr_resp_c);
                  end
               end
            end
            WR_RESP: begin
               if (axi_mosi_i.bready) begin
                  bvalid_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            RD_DATA: begin
               if (axi_mosi_i.rready) begin
                  if (rlast_q) begin
                     rvalid_q <= 1'b0;
                     rlast_q  <= 1'b0;
                     state_q  <= IDLE;
                  end else begin
                     addr_q  <= next_addr_c;
                     beat_q  <= beat_q + 8'd1;
                     rdata_q <= rd_data_c;
                     rresp_q <= rd_resp_c;
                     rlast_q <= ((beat_q + 8'd1) == len_q);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Collect the slave-side channel signals into the response bus.
   always_comb begin
      axi_miso_o         = '0;
      axi_miso_o.awready = awready_c;
      axi_miso_o.wready  = wready_c;
      axi_miso_o.bid     = id_q;
      axi_miso_o.bresp   = bresp_q;
      axi_miso_o.bvalid  = bvalid_q;
      axi_miso_o.arready = arready_c;
      axi_miso_o.rid     = id_q;
      axi_miso_o.rdata   = rdata_q;
      axi_miso_o.rresp   = rresp_q;
      axi_miso_o.rlast   = rlast_q;
      axi_miso_o.rvalid  = rvalid_q;
   end

endmodule

// File: tb/tb_jtag_axi_mem_slave.sv
// Directed testbench for jtag_axi_mem_slave with a reference memory model and response queues.
module tb_jtag_axi_mem_slave;
   import jtag_axi_mem_pkg::*;

   localparam int unsigned DEPTH = 256;
   localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef JTAG_AXI_MEM_DECERR_EN
   localparam bit DEC = 1'b1;
`else
   localparam bit DEC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   s_axi_mosi_t mosi;
   s_axi_miso_t miso;

   int checks = 0;
   int errors = 0;

   logic [31:0] model [DEPTH];
   logic [31:0] wd [16];
   logic [31:0] rq_data [$];
   logic [1:0]  rq_resp [$];
   logic        rq_last [$];
   logic [1:0]  bq [$];
   logic [3:0]  exp_bid;
   logic [3:0]  exp_rid;

   jtag_axi_mem_slave #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk_axi   (clk),
      .ares_axi  (rst),
      .axi_mosi_i(mosi),
      .axi_miso_o(miso)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned tidx(input logic [31:0] a);
      return ((a - BASE) >> 2) % DEPTH;
   endfunction

   function automatic bit toor(input logic [31:0] a);
      return (a < BASE) || (((a - BASE) >> 2) >= DEPTH);
   endfunction

   function automatic bit terr(input logic [2:0] size, input logic [1:0] burst);
      return (size != 3'd2) || (burst == 2'd2) || (burst == 2'd3);
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [3:0] strb);
      logic [31:0] a;
      a = addr;
      if (terr(size, burst)) return;
      for (int i = 0; i <= int'(len); i++) begin
         if (!(DEC && toor(a))) begin
            for (int b = 0; b < 4; b++)
               if (strb[b]) model[tidx(a)][8*b +: 8] = wd[i][8*b +: 8];
         end
         if (burst == 2'd1) a = a + 32'd4;
      end
   endtask

   task automatic exp_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
      logic [31:0] a;
      a = addr;
      for (int i = 0; i <= int'(len); i++) begin
         if (terr(size, burst)) begin
            rq_data.push_back(32'h0); rq_resp.push_back(2'b10);
         end else if (DEC && toor(a)) begin
            rq_data.push_back(32'h0); rq_resp.push_back(2'b11);
         end else begin
            rq_data.push_back(model[tidx(a)]); rq_resp.push_back(2'b00);
         end
         rq_last.push_back(i == int'(len));
         if (burst == 2'd1) a = a + 32'd4;
      end
   endtask

   task automatic aw_start(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
      mosi.awaddr = addr; mosi.awlen = len; mosi.awsize = size; mosi.awburst = burst;
      mosi.awid = id; mosi.awvalid = 1'b1;
   endtask

   task automatic ar_start(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
      mosi.araddr = addr; mosi.arlen = len; mosi.arsize = size; mosi.arburst = burst;
      mosi.arid = id; mosi.arvalid = 1'b1;
   endtask

   task automatic aw_finish();
      #1;
      for (int t = 0; t < 20 && !miso.awready; t++) begin @(negedge clk); #1; end
      chk("awready", 64'(miso.awready), 64'(1));
      @(negedge clk);
      mosi.awvalid = 1'b0;
   endtask

   task automatic ar_finish();
      #1;
      for (int t = 0; t < 20 && !miso.arready; t++) begin @(negedge clk); #1; end
      chk("arready", 64'(miso.arready), 64'(1));
      @(negedge clk);
      mosi.arvalid = 1'b0;
      #1;
      chk("rvalid_latency", 64'(miso.rvalid), 64'(1));
   endtask

   task automatic w_phase(input logic [7:0] len, input logic [3:0] strb, input bit bad_last);
      for (int i = 0; i <= int'(len); i++) begin
         mosi.wdata  = wd[i];
         mosi.wstrb  = strb;
         mosi.wlast  = bad_last ? (i == 0) : (i == int'(len));
         mosi.wvalid = 1'b1;
         #1;
         for (int t = 0; t < 20 && !miso.wready; t++) begin @(negedge clk); #1; end
         chk("wready", 64'(miso.wready), 64'(1));
         @(negedge clk);
      end
      mosi.wvalid = 1'b0;
      mosi.wlast  = 1'b0;
      #1;
      chk("bvalid_latency", 64'(miso.bvalid), 64'(1));
   endtask

   task automatic b_phase();
      logic [1:0] eb;
      eb = bq.pop_front();
      mosi.bready = 1'b0;
      chk("bvalid", 64'(miso.bvalid), 64'(1));
      chk("bresp", 64'(miso.bresp), 64'(eb));
      chk("bid", 64'(miso.bid), 64'(exp_bid));
      @(negedge clk); #1;
      chk("bvalid_hold", 64'(miso.bvalid), 64'(1));
      chk("bresp_hold", 64'(miso.bresp), 64'(eb));
      mosi.bready = 1'b1;
      @(negedge clk);
      mosi.bready = 1'b0;
      #1;
      chk("bvalid_drop", 64'(miso.bvalid), 64'(0));
   endtask

   task automatic r_phase(input bit toggle);
      while (rq_data.size() > 0) begin
         logic [31:0] ed;
         logic [1:0]  er;
         logic        el;
         ed = rq_data.pop_front(); er = rq_resp.pop_front(); el = rq_last.pop_front();
         #1;
         for (int t = 0; t < 20 && !miso.rvalid; t++) begin @(negedge clk); #1; end
         chk("rvalid", 64'(miso.rvalid), 64'(1));
         if (toggle) begin
            mosi.rready = 1'b0;
            @(negedge clk); #1;
            chk("rvalid_hold", 64'(miso.rvalid), 64'(1));
            chk("rdata_hold", 64'(miso.rdata), 64'(ed));
            chk("rlast_hold", 64'(miso.rlast), 64'(el));
         end
         chk("rdata", 64'(miso.rdata), 64'(ed));
         chk("rresp", 64'(miso.rresp), 64'(er));
         chk("rlast", 64'(miso.rlast), 64'(el));
         chk("rid", 64'(miso.rid), 64'(exp_rid));
         mosi.rready = 1'b1;
         @(negedge clk);
      end
      mosi.rready = 1'b0;
      #1;
      chk("rvalid_drop", 64'(miso.rvalid), 64'(0));
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] strb, input bit bad_last,
                            input logic [1:0] resp, input logic [3:0] id);
      bq.push_back(resp);
      exp_bid = id;
      model_write(addr, len, size, burst, strb);
      @(negedge clk);
      aw_start(addr, len, size, burst, id);
      aw_finish();
      w_phase(len, strb, bad_last);
      b_phase();
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input bit toggle);
      exp_read(addr, len, size, burst);
      exp_rid = id;
      @(negedge clk);
      ar_start(addr, len, size, burst, id);
      ar_finish();
      r_phase(toggle);
   endtask

   initial begin
      mosi = '0;
      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("reset_miso", 64'(miso), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("idle_awready", 64'(miso.awready), 64'(1));
      chk("idle_arready", 64'(miso.arready), 64'(1));

      // Single write then read
      wd[0] = 32'hDEAD_BEEF;
      axi_write(BASE + 32'h10, 8'd0, 3'd2, 2'd1, 4'hF, 1'b0, 2'b00, 4'h3);
      axi_read(BASE + 32'h10, 8'd0, 3'd2, 2'd1, 4'h5, 1'b0);

      // INCR burst write, then read with rready toggling
      wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
      axi_write(BASE, 8'd3, 3'd2, 2'd1, 4'hF, 1'b0, 2'b00, 4'h1);
      axi_read(BASE, 8'd3, 3'd2, 2'd1, 4'h2, 1'b1);
      axi_read(BASE, 8'd3, 3'd2, 2'd1, 4'h6, 1'b0);

      // Partial strobe
      wd[0] = 32'h1111_1111;
      axi_write(BASE + 32'h30, 8'd0, 3'd2, 2'd1, 4'hF, 1'b0, 2'b00, 4'h4);
      wd[0] = 32'hAABB_CCDD;
      axi_write(BASE + 32'h30, 8'd0, 3'd2, 2'd1, 4'b0101, 1'b0, 2'b00, 4'h4);
      axi_read(BASE + 32'h30, 8'd0, 3'd2, 2'd1, 4'h7, 1'b0);

      // Simultaneous AW and AR: the write wins, the read sees its data
      wd[0] = 32'h5;
      axi_write(BASE + 32'h20, 8'd0, 3'd2, 2'd1, 4'hF, 1'b0, 2'b00, 4'h8);
      wd[0] = 32'h9;
      bq.push_back(2'b00);
      exp_bid = 4'h9;
      model_write(BASE + 32'h20, 8'd0, 3'd2, 2'd1, 4'hF);
      @(negedge clk);
      aw_start(BASE + 32'h20, 8'd0, 3'd2, 2'd1, 4'h9);
      ar_start(BASE + 32'h20, 8'd0, 3'd2, 2'd1, 4'hA);
      #1;
      chk("both_awready", 64'(miso.awready), 64'(1));
      chk("both_arready", 64'(miso.arready), 64'(0));
      aw_finish();
      #1;
      chk("wr_arready", 64'(miso.arready), 64'(0));
      w_phase(8'd0, 4'hF, 1'b0);
      b_phase();
      exp_read(BASE + 32'h20, 8'd0, 3'd2, 2'd1);
      exp_rid = 4'hA;
      ar_finish();
      r_phase(1'b0);

      // Bad size write leaves memory unchanged
      wd[0] = 32'h1234_5678;
      axi_write(BASE + 32'h10, 8'd0, 3'd1, 2'd1, 4'hF, 1'b0, 2'b10, 4'hB);
      axi_read(BASE + 32'h10, 8'd0, 3'd2, 2'd1, 4'hC, 1'b0);

      // wlast mismatch: SLVERR but every beat still written
      wd[0] = 32'hCAFE_0001; wd[1] = 32'hCAFE_0002;
      axi_write(BASE + 32'h40, 8'd1, 3'd2, 2'd1, 4'hF, 1'b1, 2'b10, 4'hD);
      axi_read(BASE + 32'h40, 8'd1, 3'd2, 2'd1, 4'hE, 1'b0);

      // WRAP read returns SLVERR with zero data
      axi_read(BASE, 8'd1, 3'd2, 2'd2, 4'h1, 1'b0);

      // Read one word past the end: DECERR or alias to word 0
      axi_read(BASE + DEPTH * 4, 8'd0, 3'd2, 2'd1, 4'h2, 1'b0);

      // Reset during beat 2 of a 4-beat read
      @(negedge clk);
      ar_start(BASE, 8'd3, 3'd2, 2'd1, 4'h3);
      ar_finish();
      mosi.rready = 1'b1;
      @(negedge clk); #1;
      chk("pre_reset_rvalid", 64'(miso.rvalid), 64'(1));
      chk("pre_reset_rdata", 64'(miso.rdata), 64'(model[1]));
      mosi.rready = 1'b0;
      rst = 1'b1;
      #1;
      chk("reset_rvalid", 64'(miso.rvalid), 64'(0));
      chk("reset_miso_mid", 64'(miso), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("post_reset_awready", 64'(miso.awready), 64'(1));
      axi_read(BASE + 32'h10, 8'd0, 3'd2, 2'd1, 4'h4, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
